// File: rtl/unidade_logica_pkg.sv
// unidade_logica_pkg
// Shared definitions for the pipelined logic unit: 3-bit opcode encodings
// and a single-bit evaluation function. Because every operation is bitwise
// with no carries, the core reuses this function once per bit. That keeps the
// package independent of WIDTH.
package unidade_logica_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_AND   = 3'd0;
   localparam opcode_t OP_OR    = 3'd1;
   localparam opcode_t OP_XOR   = 3'd2;
   localparam opcode_t OP_NAND  = 3'd3;
   localparam opcode_t OP_NOR   = 3'd4;
   localparam opcode_t OP_XNOR  = 3'd5;
   localparam opcode_t OP_NOTA  = 3'd6;
   localparam opcode_t OP_PASSB = 3'd7;

   // Result of operation 'op' applied to one bit of A and one bit of B.
   function automatic logic logic_op(input opcode_t op, input logic a, input logic b);
      logic r;
      r = 1'b0;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_XOR:   r = a ^ b;
         OP_NAND:  r = ~(a & b);
         OP_NOR:   r = ~(a | b);
         OP_XNOR:  r = ~(a ^ b);
         OP_NOTA:  r = ~a;
         OP_PASSB: r = b;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/unidade_logica_pipe_logic_core.sv
// logic_core
// Purely combinational WIDTH-bit bitwise logic unit.
// Ports:
//   op_i  [2:0]        operation select (see unidade_logica_pkg)
//   a_i   [WIDTH-1:0]  operand A
//   b_i   [WIDTH-1:0]  operand B
//   r_o   [WIDTH-1:0]  result
module logic_core
   import unidade_logica_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] r_o
);

   // NOTE: combinational blocks assign a default before the loop, so no path can leave r_o unassigned and infer a latch.
   always_comb begin
      r_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r_o[i] = logic_op(op_i, a_i[i], b_i[i]);
      end
   end

endmodule

// File: rtl/unidade_logica_pipe.sv
// unidade_logica_pipe
// Registered WIDTH-bit logic unit. It has one output pipeline stage with a
// valid/ready handshake on both sides, zero/msb flags, and an optional
// accumulator that replaces operand A.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   valid_in / ready_in   input handshake (ready_in = !valid_out | ready_out)
//   op, acc_en, acc_clr   operation select, accumulator mode, accumulator clear
//   entrada1, entrada2    operands A and B
//   valid_out / ready_out output handshake
//   resultado, zero, msb  registered result and flags
//   acc                   current accumulator value
module unidade_logica_pipe
   import unidade_logica_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             acc_clr,
   input  logic [WIDTH-1:0] entrada1,
   input  logic [WIDTH-1:0] entrada2,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [WIDTH-1:0] resultado,
   output logic             zero,
   output logic             msb,
   output logic [WIDTH-1:0] acc
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             msb_q, msb_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             xfer_in, xfer_out;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] r;

   // The stage can take a new input whenever it is empty or is being drained
   // this cycle. This gives full throughput with no valid_in -> valid_out path.
   assign ready_in  = !valid_q || ready_out;
   assign xfer_in   = valid_in && ready_in;
   assign xfer_out  = valid_q && ready_out;
   assign operand_a = acc_en ? acc_q : entrada1;

   logic_core #(.WIDTH(WIDTH)) u_core (
      .op_i (op),
      .a_i  (operand_a),
      .b_i  (entrada2),
      .r_o  (r)
   );

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      msb_d    = msb_q;
      acc_d    = acc_q;

      if (xfer_in) begin
         valid_d  = 1'b1;
         result_d = r;
         zero_d   = (r == '0);
         msb_d    = r[WIDTH-1];
      end else if (xfer_out) begin
         valid_d  = 1'b0;
      end

      // The clear is independent of the handshake. It is evaluated last, so it
      // overrides a write from an acc_en transfer in the same cycle.
      if (xfer_in && acc_en) acc_d = r;
      if (acc_clr)           acc_d = ACC_INIT;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
         msb_q    <= 1'b0;
         acc_q    <= ACC_INIT;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         msb_q    <= msb_d;
         acc_q    <= acc_d;
      end
   end

   assign valid_out = valid_q;
   assign resultado = result_q;
   assign zero      = zero_q;
   assign msb       = msb_q;
   assign acc       = acc_q;

endmodule

// File: doc/unidade_logica_pipe.md
Name: unidade_logica_pipe

Overview:
- Parametrised, registered successor to the single-bit 2-input AND cell.
- WIDTH-bit logic unit with eight bitwise operations and an optional accumulator mode, where operand A is an internal register instead of entrada1.
- One output pipeline stage with valid/ready handshake on both sides, plus zero/msb flags.
- Sits between the 8-bit processor's register-file read stage and its writeback mux.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- ACC_INIT, {WIDTH{1'b0}}, accumulator value after reset and after acc_clr.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  input transaction offered.
- ready_in  out  1  unit can accept; a transfer occurs when valid_in & ready_in.
- op  in  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS B.
- acc_en  in  1  when 1, operand A = accumulator and the result is written back to the accumulator.
- acc_clr  in  1  synchronous clear of the accumulator to ACC_INIT.
- entrada1  in  WIDTH  operand A (used when acc_en=0).
- entrada2  in  WIDTH  operand B.
- valid_out  out  1  resultado holds an unconsumed result.
- ready_out  in  1  consumer accepts; a transfer occurs when valid_out & ready_out.
- resultado  out  WIDTH  registered result.
- zero  out  1  registered, resultado == 0.
- msb  out  1  registered, resultado[WIDTH-1].
- acc  out  WIDTH  current accumulator value (debug/visibility).

Behaviour:
- Reset (reset_n=0, asynchronous): valid_out=0, resultado=0, zero=1, msb=0, acc=ACC_INIT. ready_in=1 immediately after reset (combinational from valid_out).
- ready_in = !valid_out | ready_out. This is a full-throughput single stage with no combinational path from valid_in to valid_out.
- On an input transfer at edge N:
  - A = acc_en ? acc : entrada1.
  - r = op(A, entrada2), computed bitwise at WIDTH bits with no carries.
  - resultado, zero, msb are loaded from r; valid_out=1 from cycle N+1 (latency 1).
- No input transfer and an output transfer: valid_out goes to 0; resultado, zero and msb hold their last value.
- Simultaneous input and output transfer: the new result replaces the old one; valid_out stays 1, giving one result per cycle.
- Stall (valid_out=1, ready_out=0): ready_in=0. resultado, zero, msb, valid_out are held stable and must not change while valid_out=1 and not consumed.
- Accumulator:
  - Written only on an input transfer with acc_en=1 (acc <= r).
  - acc_clr is independent of the handshake: acc <= ACC_INIT at the edge.
- acc_clr together with an acc_en transfer in the same cycle:
  - The operation uses the old acc value.
  - Clear wins the write: acc = ACC_INIT afterwards.
  - resultado still shows r.
- Operations 6 and 7: the unused operand is ignored. op 6 with acc_en=1 yields ~acc.
- Inputs while valid_in=0 are don't-care; no state changes except acc_clr.
- Reset mid-stall: the pending result is discarded; the result-side handshake restarts clean.
- WIDTH=1 must work (msb == resultado[0]).

Decomposition:
- Shared package unidade_logica_pkg:
  - Opcode localparams OP_AND..OP_PASSB (3-bit).
  - Function logic_op(op, a, b) returning the bitwise result.
- One natural sub-module: logic_core, purely combinational (op, a, b -> r, WIDTH-parametrised).
- The top holds the accumulator, output register and handshake.

Test Plan:
- WIDTH=8, ready_out=1, entrada1=8'hF0, entrada2=8'h3C, op=0..7 on consecutive cycles:
  - Required resultado: 30, FC, CC, CF, 03, 33, 0F, 3C.
  - Each result appears exactly one cycle after its transfer; valid_out is continuously 1.
- entrada1=8'hAA, entrada2=8'h55, op=AND -> resultado=00, zero=1, msb=0. op=OR -> FF, zero=0, msb=1.
- Backpressure: hold ready_out=0 after the first result:
  - ready_in=0 and resultado is stable for 5 cycles while valid_in=1 with changing operands.
  - Release ready_out: the queued input is accepted the same cycle and its result follows the next cycle. No loss, no duplication.
- Accumulator:
  - acc_clr, then acc_en=1, op=OR, entrada2 = 01, 02, 04 -> acc and resultado = 01, 03, 07.
  - Then op=XOR, entrada2=07 -> 00, zero=1.
- Clear collision: acc=07, acc_en=1, op=OR, entrada2=08, acc_clr=1 in the same cycle -> resultado=0F, acc=00 afterwards.
- Reset mid-stall:
  - With valid_out=1 and ready_out=0, pulse reset_n low between clock edges.
  - Required: valid_out=0, resultado=0, zero=1, acc=ACC_INIT immediately, without waiting for a clock edge.
  - Also run one pass with WIDTH=1 and WIDTH=16: AND/OR/NOT truth checks.
